raw10_pixel_serializer: RTL and testbench

Downstream stage of the MIPI RAW10 unpacker. Accepts unpacked 4-pixel quads (40 bits), buffers them in a small FIFO, and emits one 10-bit pixel per cycle on a ready/valid stream. It optionally subtracts a black level with clamp-at-zero, and tags each pixel with start-of-line and end-of-line markers from a programmable line width. Its output feeds the per-pixel ISP pipeline.

---
 rtl/raw10_pkg.sv | 35 +++
 rtl/raw10_quad_fifo.sv | 58 +++++
 rtl/raw10_pixel_serializer.sv | 173 +++++++++++++++++
 tb/tb_raw10_pixel_serializer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw10_pkg.sv
// Shared types, widths and pixel helpers for the RAW10 pixel serializer.
package raw10_pkg;

    localparam int PIX_W        = 10;
    localparam int QUAD_W       = 40;
    localparam int PIX_PER_QUAD = 4;

    // Index of the last pixel in a quad.
    localparam logic [1:0] LAST_IDX = 2'(PIX_PER_QUAD - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Black-level subtract with clamp at zero; never wraps.
    function automatic logic [PIX_W-1:0] blc_clamp(input logic [PIX_W-1:0] pix,
                                                   input logic [PIX_W-1:0] bl);
        return (pix > bl) ? (pix - bl) : '0;
    endfunction

    // Pixel idx of a quad in line order: pixel0 lives in the top bits.
    function automatic logic [PIX_W-1:0] quad_pixel(input logic [QUAD_W-1:0] quad,
                                                    input logic [1:0]        idx);
        logic [PIX_W-1:0] pix;
        case (idx)
            2'd0:    pix = quad[39:30];
            2'd1:    pix = quad[29:20];
            2'd2:    pix = quad[19:10];
            default: pix = quad[9:0];
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/raw10_quad_fifo.sv
// Synchronous quad FIFO with full/empty flags; head is visible on o_rd_data.
module raw10_quad_fifo
    import raw10_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [QUAD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [QUAD_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic [QUAD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/raw10_pixel_serializer.sv
// RAW10 quad-to-pixel serializer with line markers.
// Optional black-level clamp is compiled in when RAW10_BLC_EN is defined.
module raw10_pixel_serializer
    import raw10_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int LINE_W_BITS = 12
) (
    input  logic                   clk_i,
    input  logic                   reset_n,
    input  logic                   quad_valid_i,
    input  logic [QUAD_W-1:0]      quad_i,
    output logic                   quad_ready_o,
    input  logic [LINE_W_BITS-1:0] line_width_i,
    input  logic [PIX_W-1:0]       black_level_i,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [PIX_W-1:0]       pix_o,
    output logic                   sol_o,
    output logic                   eol_o,
    output logic                   overflow_o
);

    ser_state_e             r_state;
    logic [QUAD_W-1:0]      r_quad;
    logic [1:0]             r_idx;
    logic                   r_pix_valid;
    logic [PIX_W-1:0]       r_pix;
    logic                   r_sol;
    logic                   r_eol;
    logic                   r_overflow;
    logic [LINE_W_BITS-1:0] r_col;
    logic [LINE_W_BITS-1:0] r_width_lat;

    logic                   w_full;
    logic                   w_empty;
    logic [QUAD_W-1:0]      w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_advance;
    logic                   w_emit;
    logic [PIX_W-1:0]       w_pix_raw;
    logic [PIX_W-1:0]       w_pix_out;
    logic                   w_col_zero;
    logic [LINE_W_BITS-1:0] w_width;
    logic                   w_eol;

    // Ready is held low during reset and is not relieved by a same-cycle pop.
    assign quad_ready_o = reset_n && !w_full;
    assign w_push       = quad_valid_i && quad_ready_o;
    assign w_advance    = !r_pix_valid || pix_ready_i;

    raw10_quad_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .i_wr_en   (w_push),
        .i_wr_data (quad_i),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Select the next pixel and decide whether the FIFO head is consumed.
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        w_pop     = 1'b0;
        w_emit    = 1'b0;
        w_pix_raw = '0;
        case (r_state)
            EMPTY: begin
                // Pixel0 goes straight from the FIFO head to the output register.
                if (w_advance && !w_empty) begin
                    w_pop     = 1'b1;
                    w_emit    = 1'b1;
                    w_pix_raw = quad_pixel(w_head, 2'd0);
                end
            end
            SHIFT: begin
                if (w_advance) begin
                    w_emit    = 1'b1;
                    w_pix_raw = quad_pixel(r_quad, r_idx);
                    // Refill behind the last pixel so quads stream without a bubble.
                    w_pop     = (r_idx == LAST_IDX) && !w_empty;
                end
            end
            default: ;
        endcase
    end

`ifdef RAW10_BLC_EN
    assign w_pix_out = blc_clamp(w_pix_raw, black_level_i);
`else
    logic w_unused_bl;
    assign w_unused_bl = ^black_level_i;
    assign w_pix_out   = w_pix_raw;
`endif

    // A new line latches its width on its first pixel; mid-line width changes wait for the next line.
    assign w_col_zero = (r_col == '0);
    assign w_width    = w_col_zero ? line_width_i : r_width_lat;
    assign w_eol      = (r_col == w_width - LINE_W_BITS'(1));

    // Serializer state, output register, column counter and sticky overflow.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_state     <= EMPTY;
            r_quad      <= '0;
            r_idx       <= '0;
            r_pix_valid <= 1'b0;
            r_pix       <= '0;
            r_sol       <= 1'b0;
            r_eol       <= 1'b0;
            r_overflow  <= 1'b0;
            r_col       <= '0;
            r_width_lat <= '0;
        end else begin
            if (quad_valid_i && !quad_ready_o) begin
                r_overflow <= 1'b1;
            end

            if (w_advance) begin
                r_pix_valid <= w_emit;
            end

            if (w_emit) begin
                r_pix <= w_pix_out;
                r_sol <= w_col_zero;
                r_eol <= w_eol;
                r_col <= w_eol ? '0 : r_col + 1'b1;
                if (w_col_zero) begin
                    r_width_lat <= line_width_i;
                end
            end

            case (r_state)
                EMPTY: begin
                    // Pixel0 was emitted during the load, so shifting resumes at pixel1.
                    if (w_pop) begin
                        r_quad  <= w_head;
                        r_idx   <= 2'd1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_advance) begin
                        if (r_idx == LAST_IDX) begin
                            if (!w_empty) begin
                                r_quad <= w_head;
                                r_idx  <= 2'd0;
                            end else begin
                                r_state <= EMPTY;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign pix_valid_o = r_pix_valid;
    assign pix_o       = r_pix;
    assign sol_o       = r_sol;
    assign eol_o       = r_eol;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_raw10_pixel_serializer.sv
// Scoreboard bench for raw10_pixel_serializer: the driver queues expected pixels,
// a negedge monitor pops them and derives sol/eol from a column model.
module tb_raw10_pixel_serializer;

    localparam int FIFO_DEPTH  = 4;
    localparam int LINE_W_BITS = 12;

    logic                   clk_i         = 1'b0;
    logic                   reset_n       = 1'b0;
    logic                   quad_valid_i  = 1'b0;
    logic [39:0]            quad_i        = '0;
    logic                   quad_ready_o;
    logic [LINE_W_BITS-1:0] line_width_i  = 12'd8;
    logic [9:0]             black_level_i = '0;
    logic                   pix_valid_o;
    logic                   pix_ready_i   = 1'b1;
    logic [9:0]             pix_o;
    logic                   sol_o;
    logic                   eol_o;
    logic                   overflow_o;

    raw10_pixel_serializer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .LINE_W_BITS (LINE_W_BITS)
    ) dut (
        .clk_i         (clk_i),
        .reset_n       (reset_n),
        .quad_valid_i  (quad_valid_i),
        .quad_i        (quad_i),
        .quad_ready_o  (quad_ready_o),
        .line_width_i  (line_width_i),
        .black_level_i (black_level_i),
        .pix_valid_o   (pix_valid_o),
        .pix_ready_i   (pix_ready_i),
        .pix_o         (pix_o),
        .sol_o         (sol_o),
        .eol_o         (eol_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    bit         exp_ovf  = 1'b0;
    int         n_pix    = 0;
    int         n_eol    = 0;
    int         run_len  = 0;
    int         max_run  = 0;

    // Monitor state: column model of the line being emitted.
    int                     m_col     = 0;
    int                     m_w       = 8;
    bit                     m_stalled = 1'b0;
    logic [9:0]             last_pix  = '0;
    bit                     last_sol  = 1'b0;
    bit                     last_eol  = 1'b0;
    logic [LINE_W_BITS-1:0] prev_lw   = 12'd8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] ref_pix(input logic [9:0] p, input logic [9:0] bl);
`ifdef RAW10_BLC_EN
        return (p > bl) ? p - bl : 10'd0;
`else
        return p + (bl & 10'd0);
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Offer one quad for one cycle; queue its pixels if the DUT takes it.
    task automatic send_quad(input logic [39:0] q, output bit acc);
        logic [39:0] qq;
        qq           = q;
        quad_valid_i = 1'b1;
        quad_i       = qq;
        @(negedge clk_i);
        acc = quad_ready_o;
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(ref_pix(qq[39-10*i -: 10], black_level_i));
            end
        end else begin
            exp_ovf = 1'b1;
        end
        @(posedge clk_i);
        #1;
        quad_valid_i = 1'b0;
    endtask

    task automatic send(input logic [39:0] q);
        bit acc;
        send_quad(q, acc);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        quad_valid_i = 1'b0;
        idle(2);
        @(negedge clk_i);
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_pix", pix_o, 0);
        check("rst_sol", sol_o, 0);
        check("rst_eol", eol_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_quad_ready", quad_ready_o, 0);
        exp_ovf = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n = 1'b1;
        @(negedge clk_i);
        check("post_rst_quad_ready", quad_ready_o, 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard       = 0;
        pix_ready_i = 1'b1;
        while ((exp_q.size() != 0 || pix_valid_o) && guard < 500) begin
            idle(1);
            guard++;
        end
        check("drain_timeout", guard < 500, 1);
        check("drain_left", exp_q.size(), 0);
        check("drain_overflow", overflow_o, exp_ovf);
    endtask

    // Monitor: pop on each newly presented pixel, check hold while stalled.
    always @(negedge clk_i) begin : mon
        logic [9:0] e;
        bit         es;
        bit         ee;
        if (!reset_n) begin
            exp_q.delete();
            m_col     = 0;
            m_stalled = 1'b0;
            run_len   = 0;
        end else begin
            if (pix_valid_o) run_len++;
            else             run_len = 0;
            if (run_len > max_run) max_run = run_len;

            if (pix_valid_o && !m_stalled) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", pix_valid_o, 0);
                end else begin
                    e  = exp_q.pop_front();
                    if (m_col == 0) m_w = int'(prev_lw);
                    es = (m_col == 0);
                    ee = (m_col == m_w - 1);
                    m_col = ee ? 0 : m_col + 1;
                    check("pix", pix_o, e);
                    check("sol", sol_o, es);
                    check("eol", eol_o, ee);
                    last_pix = e;
                    last_sol = es;
                    last_eol = ee;
                    n_pix++;
                    if (ee) n_eol++;
                end
            end else if (pix_valid_o && m_stalled) begin
                check("hold_pix", pix_o, last_pix);
                check("hold_sol", sol_o, last_sol);
                check("hold_eol", eol_o, last_eol);
            end
            m_stalled = pix_valid_o && !pix_ready_i;
        end
        prev_lw = line_width_i;
    end

    initial begin : main
        bit acc;
        int n_acc;
        int base;
        int guard;

        do_reset();

        // Latency and pixel order for one quad (values clamp when the black level is compiled in).
        black_level_i = 10'h040;
        line_width_i  = 12'd8;
        pix_ready_i   = 1'b1;
        send({10'h3FF, 10'h200, 10'h040, 10'h001});
        @(negedge clk_i);
        check("lat_n1_valid", pix_valid_o, 0);
        repeat (4) begin
            @(negedge clk_i);
            check("lat_burst_valid", pix_valid_o, 1);
        end
        @(negedge clk_i);
        check("lat_n6_valid", pix_valid_o, 0);
        @(posedge clk_i);
        #1;
        drain();

        // Back-to-back quads on an 8-wide line: 16 pixels with no bubble.
        do_reset();
        line_width_i = 12'd8;
        max_run      = 0;
        base         = n_eol;
        for (int i = 0; i < 4; i++) send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        drain();
        check("b2b_run_len", max_run, 16);
        check("b2b_eol_count", n_eol - base, 2);

        // Stall output while quads are offered every cycle.
        do_reset();
        pix_ready_i = 1'b0;
        n_acc       = 0;
        for (int i = 0; i < 10; i++) begin
            send_quad({$urandom, $urandom} & 40'hFF_FFFF_FFFF, acc);
            if (acc) n_acc++;
        end
        check("stall_accepted", n_acc, FIFO_DEPTH + 1);
        check("stall_ready_low", quad_ready_o, 0);
        check("stall_overflow", overflow_o, 1);
        check("stall_valid", pix_valid_o, 1);
        idle(2);
        drain();

        // Reset in the middle of an 8-wide line.
        do_reset();
        line_width_i = 12'd8;
        base         = n_pix;
        send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        guard = 0;
        while (n_pix - base < 6 && guard < 50) begin
            idle(1);
            guard++;
        end
        check("midline_wait_timeout", guard < 50, 1);
        reset_n = 1'b0;
        idle(1);
        check("midrst_pix_valid", pix_valid_o, 0);
        check("midrst_pix", pix_o, 0);
        check("midrst_sol", sol_o, 0);
        check("midrst_eol", eol_o, 0);
        check("midrst_quad_ready", quad_ready_o, 0);
        exp_ovf = 1'b0;
        reset_n = 1'b1;
        idle(1);
        send({10'h111, 10'h222, 10'h333, 10'h0AA});
        guard = 0;
        while (!pix_valid_o && guard < 20) begin
            idle(1);
            guard++;
        end
        check("post_midrst_timeout", guard < 20, 1);
        check("post_midrst_sol", sol_o, 1);
        drain();

        // Width change mid-line: 8-wide line completes, then 4-wide lines.
        do_reset();
        line_width_i = 12'd8;
        base         = n_eol;
        send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        line_width_i = 12'd4;
        send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
        drain();
        check("width_change_eols", n_eol - base, 3);

        // Randomized traffic with backpressure, gaps and occasional width changes.
        do_reset();
        black_level_i = 10'($urandom);
        line_width_i  = {10'($urandom_range(1, 6)), 2'b00};
        for (int c = 0; c < 400; c++) begin
            pix_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) line_width_i = {10'($urandom_range(1, 6)), 2'b00};
            if ($urandom_range(0, 2) != 0) send({$urandom, $urandom} & 40'hFF_FFFF_FFFF);
            else                           idle(1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
